gbus_burst_controller: RTL and testbench
========================================

# gbus_burst_controller

Parametrised successor to the global-bus controller. It arbitrates `NUM_REQ` requesters onto one shared global bus, with a registered, one-hot grant. An owner may hold the bus for a multi-beat burst of up to `MAX_BURST` beats. The bus output is a single registered stage with consumer backpressure. The block sits between the per-core bus request ports and the global bus fabric.

## Interface
- `NUM_REQ`, 8: number of requesters, ≥2.
- `PKT_W`, 64: packet width in bits (flat vector; the `BUS_PACKET` struct is packed into it).
- `MAX_BURST`, 4: maximum beats per grant, ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `bus_req_array` in `NUM_REQ`: per-requester request; doubles as beat-valid.
- `bus_last_array` in `NUM_REQ`: the current beat is the last of the burst.
- `in_bus_packet_array` in `NUM_REQ*PKT_W`: per-requester packet; slice i is `[i*PKT_W +: PKT_W]`.
- `bus_grant_array` out `NUM_REQ`: registered one-hot owner; all zero when no owner.
- `bus_accept` out 1: combinational; the owner's beat is taken this cycle.
- `bus_packet` out `PKT_W`: registered bus data.
- `bus_packet_vld` out 1: registered bus valid.
- `bus_ready` in 1: the consumer takes `bus_packet` this cycle.

## Operation
- FSM has two states, ARB and OWN. Reset state is ARB.
- **ARB**
  - If any request bit is set, pick a winner with `gbus_rr_arbiter`.
  - Next cycle: `bus_grant_array` is the winner's one-hot, state is OWN, and `beat_cnt` is 0.
  - With no request, state stays ARB.
  - No beat is accepted in ARB.
- **OWN** (owner o)
  - `bus_accept = grant[o] & req[o] & (~bus_packet_vld | bus_ready)`.
  - On accept: `bus_packet` loads slice o, `bus_packet_vld` goes to 1, and `beat_cnt` increments.
- **Release** (next cycle: grant goes to 0, state goes to ARB) when any of the following holds:
  - An accepted beat has `last[o]` set.
  - An accepted beat makes `beat_cnt == MAX_BURST - 1`, which forces release at `MAX_BURST` beats.
  - `req[o]` is low (owner withdrew). No beat is taken in that cycle.
- **Output register**
  - When `bus_packet_vld & bus_ready` and there is no accept in the same cycle, `bus_packet_vld` goes to 0.
  - `bus_packet` holds its value while `vld & ~ready`.
  - An accept and a drain in the same cycle give back-to-back beats with no bubble.
- `bus_last_array` and `in_bus_packet_array` of non-owners are ignored.
- `beat_cnt` width is `$clog2(MAX_BURST+1)`. It never wraps, because release occurs first.
- A requester holding `req` with `last` on every beat gets single-beat grants.

## Timing
- Reset values: `bus_grant_array` = 0, `bus_packet` = 0, `bus_packet_vld` = 0, state = ARB, `beat_cnt` = 0, rr pointer = 0. `bus_accept` is 0 in reset because grant is 0.
- Latency:
  - req rising at cycle 0 → grant at cycle 1.
  - First accept at cycle 1 (if ready) → `bus_packet_vld` at cycle 2.
- Arbitration bubble: each release leaves one ARB cycle with no grant, so the minimum spacing between grants to different owners is 1 idle cycle.
- A release cycle and a new req arriving in the same cycle: the new req is arbitrated in the following ARB cycle.
- Reset asserted mid-burst: all state clears at that edge. The partial burst is lost, and requesters must re-request.
- No combinational path from `bus_ready` to `bus_grant_array`. The only combinational path is `bus_ready` → `bus_accept`.

## Configuration
- `GBUS_ROUND_ROBIN_EN` defined:
  - Round-robin priority.
  - Search starts at the rr pointer.
  - On release, the pointer becomes (o+1) mod `NUM_REQ`.
- `GBUS_ROUND_ROBIN_EN` undefined:
  - Fixed priority; the lowest index wins.
  - The rr pointer register is not generated.

## Structure
- `gbus_pkg` holds:
  - `BUS_PACKET` typedef and `BUS_PKT_W`.
  - FSM state enum `gbus_ctrl_state_e` (ARB, OWN).
  - Default localparams for `NUM_REQ` and `MAX_BURST`.
- `gbus_rr_arbiter` is a combinational sub-module.
  - Inputs: `req`, `ptr`. Output: one-hot `winner`.
  - It contains the rotate, priority-pick and unrotate logic.
  - Under fixed priority `ptr` is tied to 0.
  - The same instance is used in both configurations.

## Test plan
- **Single request:** req[3] high with last=1 and ready=1 at cycle 0 → grant=8'b0000_1000 at cycle 1; vld=1 with req 3's packet at cycle 2; grant=0 at cycle 2.
- **Burst cap:** `MAX_BURST`=4, req[0] held with last=0 and ready=1 → exactly 4 accepts, then grant drops, then 1 idle cycle, then req[0] is re-granted.
- **Backpressure:** ready low for 3 cycles while the owner bursts → `bus_packet` is stable with vld=1, there are no accepts, and there is no data loss. After ready rises, beats stream back-to-back.
- **Round-robin fairness:** all 8 reqs continuously high with last=1 → grants cycle in order 0,1,…,7,0. With the macro off, req 0 always wins.
- **Owner withdraw:** req[5] granted, req[5] drops before its first beat → no accept, grant=0 next cycle, state ARB.
- **Reset mid-burst:** rst_n low during OWN after 2 beats → next cycle grant=0, vld=0, `bus_packet`=0, rr pointer=0.

Source files
------------

// File: rtl/gbus_pkg.sv
// Shared types and defaults for the global-bus burst controller.
// The round-robin option is selected with the GBUS_ROUND_ROBIN_EN macro.
package gbus_pkg;

    typedef struct packed {
        logic [7:0]  dst;
        logic [7:0]  src;
        logic [15:0] tag;
        logic [31:0] data;
    } BUS_PACKET;

    localparam int BUS_PKT_W = $bits(BUS_PACKET);

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } gbus_ctrl_state_e;

    localparam int GBUS_NUM_REQ   = 8;
    localparam int GBUS_MAX_BURST = 4;

endpackage

// File: rtl/gbus_rr_arbiter.sv
// Combinational rotating-priority picker: the search starts at ptr and wraps.
// With ptr tied to zero it degenerates to lowest-index-wins.
module gbus_rr_arbiter #(
    parameter int N     = 8,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] pick_dbl;
    logic [N-1:0]   rotated;
    logic [N-1:0]   pick;

    // Doubling the vector turns a modulo-N rotate into a plain shift.
    assign req_dbl  = {req, req} >> ptr;
    assign rotated  = req_dbl[N-1:0];
    assign pick     = rotated & (~rotated + N'(1));
    assign pick_dbl = {pick, pick} << ptr;
    assign winner   = pick_dbl[2*N-1:N];

endmodule

// File: rtl/gbus_burst_controller.sv
// Arbitrates NUM_REQ requesters onto one global bus with bursts of up to MAX_BURST beats.
// Define GBUS_ROUND_ROBIN_EN for round-robin priority; otherwise the lowest index wins.
module gbus_burst_controller
    import gbus_pkg::*;
#(
    parameter int NUM_REQ   = GBUS_NUM_REQ,
    parameter int PKT_W     = BUS_PKT_W,
    parameter int MAX_BURST = GBUS_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       bus_req_array,
    input  logic [NUM_REQ-1:0]       bus_last_array,
    input  logic [NUM_REQ*PKT_W-1:0] in_bus_packet_array,
    output logic [NUM_REQ-1:0]       bus_grant_array,
    output logic                     bus_accept,
    output logic [PKT_W-1:0]         bus_packet,
    output logic                     bus_packet_vld,
    input  logic                     bus_ready
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    gbus_ctrl_state_e   state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [PKT_W-1:0]   pkt_q;
    logic               vld_q;

    logic [NUM_REQ-1:0] winner;
    logic [PTR_W-1:0]   arb_ptr;
    logic [PTR_W-1:0]   owner_idx;
    logic [PKT_W-1:0]   owner_pkt;
    logic               owner_req;
    logic               owner_last;
    logic               any_req;
    logic               accept;
    logic               release_bus;
    logic               load_grant;

    // Owner decode; non-owner last/packet inputs never reach the datapath.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        owner_idx = '0;
        owner_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = PTR_W'(i);
                owner_pkt = in_bus_packet_array[i*PKT_W +: PKT_W];
            end
        end
    end

    assign owner_req  = |(grant_q & bus_req_array);
    assign owner_last = |(grant_q & bus_last_array);
    assign any_req    = |bus_req_array;

    gbus_rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arbiter (
        .req    (bus_req_array),
        .ptr    (arb_ptr),
        .winner (winner)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB: if (any_req) state_d = OWN;
            OWN: if (release_bus) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // FSM outputs: accept, release and grant load
    always_comb begin
        accept      = 1'b0;
        release_bus = 1'b0;
        load_grant  = 1'b0;
        unique case (state_q)
            ARB: load_grant = any_req;
            OWN: begin
                accept      = owner_req & (~vld_q | bus_ready);
                release_bus = ~owner_req
                            | (accept & (owner_last | (beat_cnt_q == CNT_W'(MAX_BURST - 1))));
            end
            default: ;
        endcase
    end

    assign bus_accept = accept;

    // Grant, beat counter and single-stage output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q    <= '0;
            beat_cnt_q <= '0;
            pkt_q      <= '0;
            vld_q      <= 1'b0;
        end else begin
            if (load_grant) begin
                grant_q    <= winner;
                beat_cnt_q <= '0;
            end else if (release_bus) begin
                grant_q    <= '0;
                beat_cnt_q <= '0;
            end else if (accept) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end

            // A drain and an accept in the same cycle keep vld high: no bubble.
            if (accept) begin
                pkt_q <= owner_pkt;
                vld_q <= 1'b1;
            end else if (bus_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

`ifdef GBUS_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_next;

    assign ptr_next = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (release_bus) begin
            ptr_q <= ptr_next;
        end
    end

    assign arb_ptr = ptr_q;
`else
    assign arb_ptr = '0;
`endif

    assign bus_grant_array = grant_q;
    assign bus_packet      = pkt_q;
    assign bus_packet_vld  = vld_q;

endmodule

// File: tb/tb_gbus_burst_controller.sv
// Scoreboard bench for gbus_burst_controller: stimulus pushes expected beats,
// an independent monitor pops and compares each beat the consumer takes.
module tb_gbus_burst_controller;
    import gbus_pkg::*;

    localparam int N  = 8;
    localparam int W  = 64;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     last = '0;
    logic [W-1:0]     pkts [N];
    logic [N*W-1:0]   pkt_flat;
    logic             ready = 1'b1;
    logic [N-1:0]     grant;
    logic             accept;
    logic [W-1:0]     bus_packet;
    logic             bus_packet_vld;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [W-1:0]     exp_q [$];

    always #5 clk = ~clk;

    always_comb begin
        pkt_flat = '0;
        for (int i = 0; i < N; i++) pkt_flat[i*W +: W] = pkts[i];
    end

    gbus_burst_controller #(
        .NUM_REQ   (N),
        .PKT_W     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bus_req_array       (req),
        .bus_last_array      (last),
        .in_bus_packet_array (pkt_flat),
        .bus_grant_array     (grant),
        .bus_accept          (accept),
        .bus_packet          (bus_packet),
        .bus_packet_vld      (bus_packet_vld),
        .bus_ready           (ready)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int r, input int b);
        BUS_PACKET p;
        p.dst  = 8'(r);
        p.src  = 8'(b);
        p.tag  = 16'hC0DE;
        p.data = 32'(r * 256 + b) ^ 32'hA5A5_5A5A;
        return W'(p);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison per beat the consumer takes.
    always @(negedge clk) begin
        if (bus_packet_vld && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_beat: got %h expected none", bus_packet);
            end else begin
                check("sb_packet", bus_packet, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) pkts[i] = '0;

        // Reset values
        tick; tick;
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_vld", bus_packet_vld, 0);
        check("rst_pkt", bus_packet, 0);
        check("rst_accept", accept, 0);
        tick; rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_grant", grant, 0);

        // Single request with last=1
        tick; req[3] = 1'b1; last[3] = 1'b1; pkts[3] = mk(3, 0);
        @(negedge clk);
        check("t1_grant_c0", grant, 0);
        check("t1_accept_c0", accept, 0);
        tick; exp_q.push_back(mk(3, 0));
        @(negedge clk);
        check("t1_grant_c1", grant, 8'b0000_1000);
        check("t1_accept_c1", accept, 1);
        tick; req[3] = 1'b0; last[3] = 1'b0;
        @(negedge clk);
        check("t1_grant_c2", grant, 0);
        check("t1_vld_c2", bus_packet_vld, 1);
        tick;
        @(negedge clk);
        check("t1_vld_c3", bus_packet_vld, 0);

        // Burst cap at MAX_BURST beats, then idle, then re-grant
        tick; req[0] = 1'b1; pkts[0] = mk(0, 0);
        @(negedge clk);
        check("t2_grant_arb", grant, 0);
        for (int b = 0; b < MB; b++) begin
            tick; pkts[0] = mk(0, b); exp_q.push_back(mk(0, b));
            @(negedge clk);
            check("t2_grant_beat", grant, 1);
            check("t2_accept_beat", accept, 1);
        end
        tick;
        @(negedge clk);
        check("t2_grant_idle", grant, 0);
        check("t2_accept_idle", accept, 0);
        tick; req[0] = 1'b0;
        @(negedge clk);
        check("t2_regrant", grant, 1);
        check("t2_withdraw_accept", accept, 0);
        tick;
        @(negedge clk);
        check("t2_grant_end", grant, 0);
        check("t2_vld_end", bus_packet_vld, 0);

        // Backpressure: 3 cycles of ready low, then back-to-back streaming
        tick; req[2] = 1'b1; pkts[2] = mk(2, 0);
        @(negedge clk);
        check("t3_grant_arb", grant, 0);
        tick; exp_q.push_back(mk(2, 0));
        @(negedge clk);
        check("t3_grant", grant, 8'b0000_0100);
        check("t3_accept0", accept, 1);
        tick; ready = 1'b0; pkts[2] = mk(2, 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick;
            @(negedge clk);
            check("t3_bp_accept", accept, 0);
            check("t3_bp_vld", bus_packet_vld, 1);
            check("t3_bp_hold", bus_packet, mk(2, 0));
        end
        tick; ready = 1'b1; exp_q.push_back(mk(2, 1));
        @(negedge clk);
        check("t3_accept1", accept, 1);
        tick; pkts[2] = mk(2, 2); exp_q.push_back(mk(2, 2));
        @(negedge clk);
        check("t3_accept2", accept, 1);
        check("t3_vld_b2b", bus_packet_vld, 1);
        tick; pkts[2] = mk(2, 3); exp_q.push_back(mk(2, 3));
        @(negedge clk);
        check("t3_accept3", accept, 1);
        check("t3_grant_b3", grant, 8'b0000_0100);
        tick; req[2] = 1'b0;
        @(negedge clk);
        check("t3_release", grant, 0);
        check("t3_vld_last", bus_packet_vld, 1);
        tick;
        @(negedge clk);
        check("t3_vld_drained", bus_packet_vld, 0);

        // Owner withdraws before its first beat
        tick; req[5] = 1'b1; last[5] = 1'b1; pkts[5] = mk(5, 0);
        @(negedge clk);
        check("t5_grant_arb", grant, 0);
        tick; req[5] = 1'b0; last[5] = 1'b0;
        @(negedge clk);
        check("t5_grant", grant, 8'b0010_0000);
        check("t5_no_accept", accept, 0);
        tick; req[1] = 1'b1; pkts[1] = mk(1, 0);
        @(negedge clk);
        check("t5_grant_drop", grant, 0);
        check("t5_no_vld", bus_packet_vld, 0);

        // Re-arbitration proves the withdraw returned to ARB; reset after 2 beats
        tick; exp_q.push_back(mk(1, 0));
        @(negedge clk);
        check("t6_grant", grant, 8'b0000_0010);
        check("t6_accept0", accept, 1);
        tick; pkts[1] = mk(1, 1); exp_q.push_back(mk(1, 1));
        @(negedge clk);
        check("t6_accept1", accept, 1);
        tick; rst_n = 1'b0; req[1] = 1'b0;
        @(negedge clk);
        tick; rst_n = 1'b1;
        @(negedge clk);
        check("t6_rst_grant", grant, 0);
        check("t6_rst_vld", bus_packet_vld, 0);
        check("t6_rst_pkt", bus_packet, 0);

        // Fairness: all requesters with last=1
        tick;
        req = '1; last = '1;
        for (int i = 0; i < N; i++) pkts[i] = mk(i, 0);
        @(negedge clk);
        check("t4_grant_arb", grant, 0);
        for (int k = 0; k <= N; k++) begin
`ifdef GBUS_ROUND_ROBIN_EN
            int owner = k % N;
`else
            int owner = 0;
`endif
            tick; exp_q.push_back(mk(owner, 0));
            @(negedge clk);
            check("t4_grant_owner", grant, W'(1) << owner);
            check("t4_accept", accept, 1);
            tick;
            if (k == N) begin
                req = '0;
                last = '0;
            end
            @(negedge clk);
            check("t4_grant_gap", grant, 0);
        end
        tick; tick;
        @(negedge clk);
        check("end_grant", grant, 0);
        check("sb_drained", W'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
